// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified memory port between instruction fetch (I) and data access (D).
// Define MEM_ARB_RR_EN to swap the D-priority streak guard for alternating round-robin arbitration.
module mem_port_arbiter #(
    parameter int MEM_LAT      = 2,
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_flush,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_half,
    output logic        mem_byte,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    state_t      r_state;
    state_t      w_state_nxt;
    owner_t      r_owner;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic        r_flushed;
    logic        w_last;
    logic        w_pick_d;
    logic        w_pick_i;
    logic        w_grant_i;
    logic        w_grant_d;

`ifndef MEM_ARB_RR_EN
    localparam int              SW         = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_D_STREAK);
    logic [SW-1:0]              r_streak;
`endif

    // Arbitration and next-state: a new owner is chosen when idle or on the last access cycle
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_last      = (r_state == ST_ACCESS) && (r_cnt == CNT_LAST);
`ifdef MEM_ARB_RR_EN
        // r_owner still names the previous owner here, so a contested grant goes to the other side
        w_pick_d    = d_req && (!i_req || (r_owner != OWN_D));
`else
        w_pick_d    = d_req && !(i_req && (r_streak == STREAK_MAX));
`endif
        w_pick_i    = i_req && !w_pick_d;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_d || w_pick_i) begin
                    w_grant_d   = w_pick_d;
                    w_grant_i   = w_pick_i;
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (w_last) begin
                    if (w_pick_d || w_pick_i) begin
                        w_grant_d   = w_pick_d;
                        w_grant_i   = w_pick_i;
                        w_state_nxt = ST_ACCESS;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifndef MEM_ARB_RR_EN
    // Count consecutive D grants taken while a fetch was waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_streak <= {SW{1'b0}};
        end else if (w_grant_i || (w_grant_d && !i_req)) begin
            r_streak <= {SW{1'b0}};
        end else if (w_grant_d && (r_streak != STREAK_MAX)) begin
            r_streak <= r_streak + SW'(1);
        end else begin
            r_streak <= r_streak;
        end
    end
`endif

    // Access datapath: latch the winner's request, count latency, return read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner   <= OWN_NONE;
            r_cnt     <= 4'd0;
            r_we      <= 1'b0;
            r_flushed <= 1'b0;
            i_gnt     <= 1'b0;
            i_rvalid  <= 1'b0;
            i_rdata   <= 32'd0;
            d_gnt     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= 32'd0;
            mem_addr  <= 32'd0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_half  <= 1'b0;
            mem_byte  <= 1'b0;
            mem_wdata <= 32'd0;
            busy      <= 1'b0;
        end else begin
            i_gnt     <= w_grant_i;
            d_gnt     <= w_grant_d;
            i_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            mem_write <= 1'b0;
            busy      <= (w_state_nxt == ST_ACCESS);
            r_cnt     <= (r_state == ST_ACCESS) ? (r_cnt + 4'd1) : r_cnt;
            // A flushed fetch still occupies the port; only its response is dropped
            if ((r_state == ST_ACCESS) && (r_owner == OWN_I) && i_flush) begin
                r_flushed <= 1'b1;
            end
            if (w_last) begin
                mem_read <= 1'b0;
                mem_half <= 1'b0;
                mem_byte <= 1'b0;
                case (r_owner)
                    OWN_I: begin
                        if (!(r_flushed || i_flush)) begin
                            i_rvalid <= 1'b1;
                            i_rdata  <= mem_rdata;
                        end
                    end
                    OWN_D: begin
                        d_rvalid <= 1'b1;
                        if (!r_we) begin
                            d_rdata <= mem_rdata;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            if (w_grant_i) begin
                r_owner   <= OWN_I;
                r_we      <= 1'b0;
                r_cnt     <= 4'd0;
                r_flushed <= 1'b0;
                mem_addr  <= i_addr;
                mem_read  <= 1'b1;
                mem_half  <= 1'b0;
                mem_byte  <= 1'b0;
            end else if (w_grant_d) begin
                r_owner   <= OWN_D;
                r_we      <= d_we;
                r_cnt     <= 4'd0;
                r_flushed <= 1'b0;
                mem_addr  <= d_addr;
                mem_read  <= !d_we;
                mem_write <= d_we;
                mem_half  <= d_size[1];
                mem_byte  <= d_size[0];
                mem_wdata <= d_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model predicts every output each cycle,
// and hand-computed latencies, grant orders and read data pin the model down.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int MEM_LAT      = 2;
    localparam int MAX_D_STREAK = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req, i_flush, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, mem_half, mem_byte, busy;

    mem_port_arbiter #(.MEM_LAT(MEM_LAT), .MAX_D_STREAK(MAX_D_STREAK)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_half(mem_half), .mem_byte(mem_byte), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int    n_assert = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    t_igt = 0, t_dgt = 0, t_irv = 0, t_drv = 0;
    int    n_irv = 0, n_drv = 0, n_wr = 0;
    string gs = "";

    // Word-addressed memory: each word initially holds A5A5 in the top half and its own byte address below
    logic [31:0] mem [0:255];
    initial for (int k = 0; k < 256; k++) mem[k] = 32'hA5A5_0000 | (k << 2);
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          busy;
        int          age;
        int          owner;   // 0 none, 1 fetch, 2 data
        int          last;
        int          streak;
        bit          flushed;
        logic [31:0] addr, wdata, ird, drd;
        logic        we, igt, dgt, irv, drv;
        logic [1:0]  size;
    } mstate_t;

    mstate_t ms;

    function automatic mstate_t m_reset();
        mstate_t r;
        r.busy = 1'b0; r.age = 0; r.owner = 0; r.last = 0; r.streak = 0; r.flushed = 1'b0;
        r.addr = 32'd0; r.wdata = 32'd0; r.ird = 32'd0; r.drd = 32'd0;
        r.we = 1'b0; r.igt = 1'b0; r.dgt = 1'b0; r.irv = 1'b0; r.drv = 1'b0; r.size = 2'b00;
        return r;
    endfunction

    // One clock of the port: age the running transaction, retire it, then pick the next one
    function automatic mstate_t m_step(input mstate_t s);
        mstate_t n = s;
        int win = 0;
        n.igt = 1'b0; n.dgt = 1'b0; n.irv = 1'b0; n.drv = 1'b0;
        if (n.busy) begin
            n.age = n.age + 1;
            if (n.owner == 1 && i_flush) n.flushed = 1'b1;
            if (n.age == MEM_LAT) begin
                n.busy = 1'b0;
                if (n.owner == 1 && !n.flushed) begin n.irv = 1'b1; n.ird = mem[n.addr[9:2]]; end
                if (n.owner == 2) begin n.drv = 1'b1; if (!n.we) n.drd = mem[n.addr[9:2]]; end
            end
        end
        if (!n.busy) begin
            if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
                win = (n.last == 2) ? 1 : 2;
`else
                win = (n.streak >= MAX_D_STREAK) ? 1 : 2;
`endif
            end else if (d_req) win = 2;
            else if (i_req) win = 1;
            if (win != 0) begin
                n.busy = 1'b1; n.age = 0; n.owner = win; n.last = win; n.flushed = 1'b0;
                if (win == 1) begin
                    n.addr = i_addr; n.we = 1'b0; n.size = 2'b00; n.igt = 1'b1; n.streak = 0;
                end else begin
                    n.addr = d_addr; n.we = d_we; n.size = d_size; n.wdata = d_wdata; n.dgt = 1'b1;
                    n.streak = !i_req ? 0 : ((n.streak < MAX_D_STREAK) ? n.streak + 1 : MAX_D_STREAK);
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) ms <= m_reset();
        else     ms <= m_step(ms);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_str(input string nm, input string act, input string exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %s required %s", nm, act, exp);
        end
    endtask

    // Compare every output with the model on the falling edge and log grant/response events
    always @(negedge clk) begin
        chk("i_gnt",     32'(i_gnt),     32'(ms.igt));
        chk("d_gnt",     32'(d_gnt),     32'(ms.dgt));
        chk("i_rvalid",  32'(i_rvalid),  32'(ms.irv));
        chk("d_rvalid",  32'(d_rvalid),  32'(ms.drv));
        chk("busy",      32'(busy),      32'(ms.busy));
        chk("i_rdata",   i_rdata,        ms.ird);
        chk("d_rdata",   d_rdata,        ms.drd);
        chk("mem_read",  32'(mem_read),  32'(ms.busy && !(ms.owner == 2 && ms.we)));
        chk("mem_write", 32'(mem_write), 32'(ms.busy && ms.owner == 2 && ms.we && ms.age == 0));
        chk("mem_half",  32'(mem_half),  32'(ms.busy && ms.owner == 2 && ms.size[1]));
        chk("mem_byte",  32'(mem_byte),  32'(ms.busy && ms.owner == 2 && ms.size[0]));
        if (ms.busy) begin
            chk("mem_addr", mem_addr, ms.addr);
            if (ms.owner == 2 && ms.we) chk("mem_wdata", mem_wdata, ms.wdata);
        end
        if (i_gnt)    begin t_igt <= cyc; gs <= {gs, "I"}; end
        if (d_gnt)    begin t_dgt <= cyc; gs <= {gs, "D"}; end
        if (i_rvalid) begin t_irv <= cyc; n_irv <= n_irv + 1; end
        if (d_rvalid) begin t_drv <= cyc; n_drv <= n_drv + 1; end
        if (mem_write) n_wr <= n_wr + 1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req_i(input logic [31:0] a);
        i_addr = a;
        i_req  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (i_gnt) break;
        end
        chk("i_gnt_wait", 32'(i_gnt), 32'd1);
        i_req = 1'b0;
    endtask

    task automatic req_d(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
        d_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (d_gnt) break;
        end
        chk("d_gnt_wait", 32'(d_gnt), 32'd1);
        d_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, r0, w0, g0;
        i_req = 1'b0; i_addr = 32'd0; i_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = 32'd0; d_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_i_rdata",  i_rdata,       32'd0);

        // Lone fetch: grant one cycle after the request, data three cycles after
        t0 = cyc;
        req_i(32'h10);
        wait_cycles(4);
        chk("t1_gnt_lat", 32'(t_igt - t0), 32'd1);
        chk("t1_rv_lat",  32'(t_irv - t0), 32'd3);
        chk("t1_rdata",   i_rdata,         32'hA5A5_0010);

        // Simultaneous requests: data first, fetch granted back-to-back with the data response
        t0 = cyc;
        fork
            req_i(32'h10);
            req_d(1'b0, 2'b00, 32'h200, 32'd0);
        join
        wait_cycles(4);
        chk("t2_dgnt_lat", 32'(t_dgt - t0), 32'd1);
        chk("t2_drv_lat",  32'(t_drv - t0), 32'd3);
        chk("t2_igt_lat",  32'(t_igt - t0), 32'd3);
        chk("t2_d_rdata",  d_rdata,         32'hA5A5_0200);

        // Both held for six grants
        g0 = gs.len();
        i_addr = 32'h20; d_addr = 32'h80; d_we = 1'b0; d_size = 2'b00;
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (gs.len() >= g0 + 6) break;
        end
        i_req = 1'b0; d_req = 1'b0;
        wait_cycles(4);
`ifdef MEM_ARB_RR_EN
        chk_str("t3_grant_order", gs.substr(g0, g0 + 5), "DIDIDI");
`else
        chk_str("t3_grant_order", gs.substr(g0, g0 + 5), "DDDDID");
`endif

        // Word store, half store, then readback of the word
        w0 = n_wr; t0 = cyc;
        req_d(1'b1, 2'b00, 32'h40, 32'hDEAD_BEEF);
        wait_cycles(4);
        chk("t4_write_cycles", 32'(n_wr - w0),   32'd1);
        chk("t4_store_rv_lat", 32'(t_drv - t0),  32'd3);
        req_d(1'b1, 2'b10, 32'h44, 32'h0000_1234);
        wait_cycles(4);
        req_d(1'b0, 2'b00, 32'h40, 32'd0);
        wait_cycles(4);
        chk("t4_readback", d_rdata, 32'hDEAD_BEEF);

        // Flush in the grant cycle, then in the second access cycle
        for (int fc = 0; fc < 2; fc++) begin
            r0 = n_irv;
            req_i(32'h10);
            if (fc == 1) begin @(posedge clk); #1; end
            i_flush = 1'b1;
            @(posedge clk); #1;
            i_flush = 1'b0;
            wait_cycles(3);
            chk("t5_flushed_no_rv", 32'(n_irv - r0), 32'd0);
            t0 = cyc;
            req_i(32'h14);
            wait_cycles(3);
            chk("t5_next_rv",     32'(n_irv - r0),  32'd1);
            chk("t5_next_rv_lat", 32'(t_irv - t0),  32'd3);
            chk("t5_next_rdata",  i_rdata,          32'hA5A5_0014);
        end

        // Reset in the middle of a load
        req_d(1'b0, 2'b00, 32'h200, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("t6_busy",     32'(busy),     32'd0);
        chk("t6_d_gnt",    32'(d_gnt),    32'd0);
        chk("t6_mem_read", 32'(mem_read), 32'd0);
        chk("t6_mem_addr", mem_addr,      32'd0);
        chk("t6_d_rdata",  d_rdata,       32'd0);
        r0 = n_drv + n_irv;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_cycles(5);
        chk("t6_no_rv", 32'(n_drv + n_irv - r0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
